rvfi_check_sequencer: RTL and testbench

RVFI_CHECK_SEQUENCER -- requirements
Module: rvfi_check_sequencer

---
 rtl/rvfi_check_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rvfi_check_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer
// Formal-harness sequencer. After reset it waits TRIG_DELAY cycles and then
// arms. It fires a single trig on a clean retire of CHANNEL_IDX and captures
// that retire's order. It then watches for order+1 on any channel. Exactly
// CHECK_DEPTH cycles after trig it pulses check, unless a halt ends the window
// first. Everything is one-shot per reset interval.
module rvfi_check_sequencer #(
    parameter int NRET        = 1,
    parameter int CHANNEL_IDX = 0,
    parameter int TRIG_DELAY  = 4,
    parameter int CHECK_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 arm_en,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET-1:0]      rvfi_halt,
    input  logic [64*NRET-1:0]   rvfi_order,
    output logic                 trig,
    output logic                 check,
    output logic [63:0]          trig_order,
    output logic                 found_next,
    output logic                 aborted,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Counter values that end the IDLE delay and the WAIT window. The window
    // counter is cleared on the trig cycle (window cycle 0). WAIT leaves when
    // the incremented count hits CHECK_DEPTH-1, so CHECK lands on trig+CHECK_DEPTH.
    localparam logic [15:0] DELAY_TARGET = TRIG_DELAY[15:0];
    localparam logic [15:0] WIN_LAST     = 16'(CHECK_DEPTH - 1);

    state_t        state_reg, state_next;
    logic [15:0]   delay_cnt_reg, delay_cnt_next;
    logic [15:0]   win_cnt_reg, win_cnt_next;
    logic [63:0]   trig_order_reg, trig_order_next;
    logic          found_reg, found_next_val;
    logic          aborted_reg, aborted_next;

    logic [63:0]   live_order;
    logic [63:0]   live_target;
    logic [63:0]   wait_target;
    logic [NRET-1:0] match_trig_vec;
    logic [NRET-1:0] match_wait_vec;
    logic [NRET-1:0] halt_vec;
    logic          match_trig;
    logic          match_wait;
    logic          halt_any;
    logic          trig_fire;

    // The trig channel's live order and both +1 targets. The adds wrap mod 2^64.
    assign live_order  = rvfi_order[64*CHANNEL_IDX +: 64];
    assign live_target = live_order + 64'd1;
    assign wait_target = trig_order_reg + 64'd1;

    // Per-channel compares: a successor retire against the live or captured
    // target, and a halt seen on a valid retire.
    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
            logic [63:0] chan_order;
            assign chan_order         = rvfi_order[64*gi +: 64];
            assign match_trig_vec[gi] = rvfi_valid[gi] && (chan_order == live_target);
            assign match_wait_vec[gi] = rvfi_valid[gi] && (chan_order == wait_target);
            assign halt_vec[gi]       = rvfi_valid[gi] && rvfi_halt[gi];
        end
    endgenerate

    assign match_trig = |match_trig_vec;
    assign match_wait = |match_wait_vec;
    assign halt_any   = |halt_vec;

    // Trig is combinational so the captured order belongs to this very retire.
    // Reset masks it so a trig can never coincide with a reset cycle.
    assign trig_fire = (state_reg == ST_ARM) && arm_en && rvfi_valid[CHANNEL_IDX]
                       && !rvfi_halt[CHANNEL_IDX] && !reset;

    // Next-state and datapath updates for the one-shot sequence.
    always_comb begin
        state_next      = state_reg;
        delay_cnt_next  = delay_cnt_reg;
        win_cnt_next    = win_cnt_reg;
        trig_order_next = trig_order_reg;
        found_next_val  = found_reg;
        aborted_next    = aborted_reg;
        case (state_reg)
            ST_IDLE: begin
                delay_cnt_next = delay_cnt_reg + 16'd1;
                if ((DELAY_TARGET == 16'd0) || (delay_cnt_next == DELAY_TARGET)) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (trig_fire) begin
                    trig_order_next = live_order;
                    win_cnt_next    = 16'd0;
                    if (match_trig) begin
                        found_next_val = 1'b1;
                    end
                    state_next = (WIN_LAST == 16'd0) ? ST_CHECK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                win_cnt_next = win_cnt_reg + 16'd1;
                if (match_wait) begin
                    found_next_val = 1'b1;
                end
                // A halt ends the window only if no successor was ever seen,
                // including one retiring in this same cycle.
                if (halt_any && !found_reg && !match_wait) begin
                    aborted_next = 1'b1;
                    state_next   = ST_DONE;
                end else if (win_cnt_next == WIN_LAST) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any open window.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            delay_cnt_reg  <= 16'd0;
            win_cnt_reg    <= 16'd0;
            trig_order_reg <= 64'd0;
            found_reg      <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            delay_cnt_reg  <= delay_cnt_next;
            win_cnt_reg    <= win_cnt_next;
            trig_order_reg <= trig_order_next;
            found_reg      <= found_next_val;
            aborted_reg    <= aborted_next;
        end
    end

    assign trig       = trig_fire;
    assign check      = (state_reg == ST_CHECK) && !reset;
    assign trig_order = trig_order_reg;
    assign found_next = found_reg;
    assign aborted    = aborted_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench for rvfi_check_sequencer (NRET=2, TRIG_DELAY=4, CHECK_DEPTH=3).
// Every step drives one cycle of inputs and queues the outputs expected in that
// cycle. A negedge monitor pops each entry and compares it with the DUT.
module tb_rvfi_check_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm_en;
    logic [1:0]    rvfi_valid;
    logic [1:0]    rvfi_halt;
    logic [127:0]  rvfi_order;
    logic          trig;
    logic          check;
    logic [63:0]   trig_order;
    logic          found_next;
    logic          aborted;
    logic [2:0]    state;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic        tr;
        logic        ck;
        logic        fd;
        logic        ab;
        logic [63:0] to;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    rvfi_check_sequencer #(
        .NRET        (2),
        .CHANNEL_IDX (0),
        .TRIG_DELAY  (4),
        .CHECK_DEPTH (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .arm_en     (arm_en),
        .rvfi_valid (rvfi_valid),
        .rvfi_halt  (rvfi_halt),
        .rvfi_order (rvfi_order),
        .trig       (trig),
        .check      (check),
        .trig_order (trig_order),
        .found_next (found_next),
        .aborted    (aborted),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input string field,
                       input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected during it.
    task automatic step(input string tag, input logic rst, input logic arm,
                        input logic [1:0] v, input logic [1:0] h,
                        input logic [63:0] o0, input logic [63:0] o1,
                        input logic [2:0] st, input logic tr, input logic ck,
                        input logic fd, input logic ab, input logic [63:0] to);
        exp_t e;
        reset      = rst;
        arm_en     = arm;
        rvfi_valid = v;
        rvfi_halt  = h;
        rvfi_order = {o1, o0};
        e.tag = tag; e.st = st; e.tr = tr; e.ck = ck; e.fd = fd; e.ab = ab; e.to = to;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: compare every queued expectation mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "state",      64'(state),  64'(e.st));
                chk(e.tag, "trig",       64'(trig),   64'(e.tr));
                chk(e.tag, "check",      64'(check),  64'(e.ck));
                chk(e.tag, "found_next", 64'(found_next), 64'(e.fd));
                chk(e.tag, "aborted",    64'(aborted), 64'(e.ab));
                chk(e.tag, "trig_order", trig_order,  e.to);
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    initial begin : stim
        reset = 1'b1; arm_en = 1'b1; rvfi_valid = 2'b11; rvfi_halt = 2'b00;
        rvfi_order = '0;
        @(posedge clock);
        #1;

        // Reset state, with arm and retires present.
        step("rst0", 1, 1, 2'b11, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);

        // Basic sequence: trig at cycle 4, successor at 5, check at 7, DONE at 8.
        for (int k = 0; k < 4; k++)
            step("t1_idle", 0, 1, 2'b01, 2'b00, 64'(k), 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        step("t1_trig",  0, 1, 2'b01, 2'b00, 64'd4, 64'd0, S_ARM,   1, 0, 0, 0, 64'd0);
        step("t1_w1",    0, 1, 2'b01, 2'b00, 64'd5, 64'd0, S_WAIT,  0, 0, 0, 0, 64'd4);
        step("t1_w2",    0, 1, 2'b01, 2'b00, 64'd6, 64'd0, S_WAIT,  0, 0, 1, 0, 64'd4);
        step("t1_check", 0, 1, 2'b01, 2'b00, 64'd7, 64'd0, S_CHECK, 0, 1, 1, 0, 64'd4);
        step("t1_done",  0, 1, 2'b01, 2'b00, 64'd8, 64'd0, S_DONE,  0, 0, 1, 0, 64'd4);
        step("t1_done2", 0, 1, 2'b01, 2'b00, 64'd9, 64'd0, S_DONE,  0, 0, 1, 0, 64'd4);

        // arm_en low holds ARM; then a same-cycle successor retires on ch1.
        step("t2_rstA", 1, 0, 2'b00, 2'b00, 64'd0, 64'd0, S_DONE, 0, 0, 1, 0, 64'd4);
        step("t2_rstB", 1, 0, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        for (int k = 0; k < 4; k++)
            step("t2_idle", 0, 0, 2'b11, 2'b00, 64'(k), 64'(k + 1), S_IDLE, 0, 0, 0, 0, 64'd0);
        for (int k = 4; k < 10; k++)
            step("t2_noarm", 0, 0, 2'b11, 2'b00, 64'(k), 64'(k + 1), S_ARM, 0, 0, 0, 0, 64'd0);
        step("t2_trig",  0, 1, 2'b11, 2'b00, 64'd10, 64'd11, S_ARM,   1, 0, 0, 0, 64'd0);
        step("t2_w1",    0, 1, 2'b00, 2'b00, 64'd0,  64'd0,  S_WAIT,  0, 0, 1, 0, 64'd10);
        step("t2_w2",    0, 1, 2'b00, 2'b00, 64'd0,  64'd0,  S_WAIT,  0, 0, 1, 0, 64'd10);
        step("t2_check", 0, 1, 2'b00, 2'b00, 64'd0,  64'd0,  S_CHECK, 0, 1, 1, 0, 64'd10);
        step("t2_done",  0, 1, 2'b00, 2'b00, 64'd0,  64'd0,  S_DONE,  0, 0, 1, 0, 64'd10);

        // Order wrap: trig on all-ones, successor order 0 retires on ch1.
        step("t3_rstA", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_DONE, 0, 0, 1, 0, 64'd10);
        step("t3_rstB", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        for (int k = 0; k < 4; k++)
            step("t3_idle", 0, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        step("t3_trig",  0, 1, 2'b01, 2'b00, ONES,  64'd0, S_ARM,   1, 0, 0, 0, 64'd0);
        step("t3_w1",    0, 1, 2'b10, 2'b00, 64'd0, 64'd0, S_WAIT,  0, 0, 0, 0, ONES);
        step("t3_w2",    0, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_WAIT,  0, 0, 1, 0, ONES);
        step("t3_check", 0, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_CHECK, 0, 1, 1, 0, ONES);
        step("t3_done",  0, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_DONE,  0, 0, 1, 0, ONES);

        // Halt at window cycle 2 with no successor: abort, no check.
        step("t4_rstA", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_DONE, 0, 0, 1, 0, ONES);
        step("t4_rstB", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        for (int k = 0; k < 4; k++)
            step("t4_idle", 0, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        step("t4_trig",  0, 1, 2'b01, 2'b00, 64'd20, 64'd0, S_ARM,  1, 0, 0, 0, 64'd0);
        step("t4_w1",    0, 1, 2'b01, 2'b00, 64'd22, 64'd0, S_WAIT, 0, 0, 0, 0, 64'd20);
        step("t4_halt",  0, 1, 2'b01, 2'b01, 64'd23, 64'd0, S_WAIT, 0, 0, 0, 0, 64'd20);
        step("t4_abort", 0, 1, 2'b00, 2'b00, 64'd0,  64'd0, S_DONE, 0, 0, 0, 1, 64'd20);
        step("t4_done",  0, 1, 2'b01, 2'b00, 64'd24, 64'd0, S_DONE, 0, 0, 0, 1, 64'd20);

        // Successor and halt in the same window cycle count as found.
        step("t5_rstA", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_DONE, 0, 0, 0, 1, 64'd20);
        step("t5_rstB", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        for (int k = 0; k < 4; k++)
            step("t5_idle", 0, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        step("t5_trig",  0, 1, 2'b01, 2'b00, 64'd30, 64'd0, S_ARM,   1, 0, 0, 0, 64'd0);
        step("t5_mhalt", 0, 1, 2'b01, 2'b01, 64'd31, 64'd0, S_WAIT,  0, 0, 0, 0, 64'd30);
        step("t5_w2",    0, 1, 2'b00, 2'b00, 64'd0,  64'd0, S_WAIT,  0, 0, 1, 0, 64'd30);
        step("t5_check", 0, 1, 2'b00, 2'b00, 64'd0,  64'd0, S_CHECK, 0, 1, 1, 0, 64'd30);
        step("t5_done",  0, 1, 2'b00, 2'b00, 64'd0,  64'd0, S_DONE,  0, 0, 1, 0, 64'd30);

        // Reset at window cycle 1 abandons the window and restarts the delay.
        step("t6_rstA", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_DONE, 0, 0, 1, 0, 64'd30);
        step("t6_rstB", 1, 1, 2'b00, 2'b00, 64'd0, 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        for (int k = 0; k < 4; k++)
            step("t6_idle", 0, 1, 2'b01, 2'b00, 64'(k), 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        step("t6_trig",  0, 1, 2'b01, 2'b00, 64'd40, 64'd0, S_ARM,  1, 0, 0, 0, 64'd0);
        step("t6_rstw",  1, 1, 2'b01, 2'b00, 64'd41, 64'd0, S_WAIT, 0, 0, 0, 0, 64'd40);
        for (int k = 0; k < 4; k++)
            step("t6_redly", 0, 1, 2'b01, 2'b00, 64'(50 + k), 64'd0, S_IDLE, 0, 0, 0, 0, 64'd0);
        step("t6_trig2", 0, 1, 2'b01, 2'b00, 64'd54, 64'd0, S_ARM,   1, 0, 0, 0, 64'd0);
        step("t6_w1",    0, 1, 2'b01, 2'b00, 64'd60, 64'd0, S_WAIT,  0, 0, 0, 0, 64'd54);
        step("t6_w2",    0, 1, 2'b01, 2'b00, 64'd61, 64'd0, S_WAIT,  0, 0, 0, 0, 64'd54);
        step("t6_check", 0, 1, 2'b01, 2'b00, 64'd62, 64'd0, S_CHECK, 0, 1, 0, 0, 64'd54);
        step("t6_done",  0, 1, 2'b01, 2'b00, 64'd63, 64'd0, S_DONE,  0, 0, 0, 0, 64'd54);

        chk("sb", "pending", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
